// File: rtl/aer_pkg.sv
// ---------------------------------------------------------------------------
// aer_pkg
//   Shared definitions for the dual-rail AER transmitter.
//
//   Contents:
//     aer_state_t  - transmitter control states (IDLE, REQ, REL, DRAIN)
//     SPACER/D0/D1/MARK - rail codes, packed as {ONE_OUT, ZERO_OUT}
//     WAIT_W       - width of the handshake wait counter
//     data_token() - maps a single data bit onto its rail code
// ---------------------------------------------------------------------------
package aer_pkg;

  // IDLE  : waiting for an address from the local source
  // REQ   : a token is on the rails, waiting for the receiver to acknowledge
  // REL   : rails are at spacer, waiting for the receiver to release ack
  // DRAIN : a handshake timed out; wait for ack to fall before going idle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    REL   = 2'd2,
    DRAIN = 2'd3
  } aer_state_t;

  // Rail codes, bit 1 drives ONE_OUT and bit 0 drives ZERO_OUT.
  // A spacer (both low) separates every pair of tokens; a MARK (both high)
  // brackets the data bits of a frame.
  localparam logic [1:0] SPACER = 2'b00;
  localparam logic [1:0] D0     = 2'b01;
  localparam logic [1:0] D1     = 2'b10;
  localparam logic [1:0] MARK   = 2'b11;

  // Wide enough for the largest legal timeout of 65535 cycles.
  localparam int WAIT_W = 16;

  // A data bit uses exactly one rail: ONE_OUT for a 1, ZERO_OUT for a 0.
  function automatic logic [1:0] data_token(input logic bit_val);
    return bit_val ? D1 : D0;
  endfunction

endpackage

// File: rtl/aer_sync.sv
// ---------------------------------------------------------------------------
// aer_sync
//   Two-flop synchronizer bringing the receiver's acknowledge (which is
//   asynchronous to clk) into the transmitter's clock domain.
//
//   Ports:
//     clk      - transmitter clock, rising edge
//     reset    - synchronous, active-high; clears both flops
//     async_in - raw asynchronous input
//     sync_out - input delayed by two clk edges, safe to use in control logic
// ---------------------------------------------------------------------------
module aer_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // The first flop may go metastable when async_in changes near the clock
  // edge; the second flop gives it a full cycle to resolve before anything
  // downstream looks at the value.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/aer_transmitter.sv
// ---------------------------------------------------------------------------
// aer_transmitter
//   Sends an address over a dual-rail, four-phase (return-to-zero) link.
//   Each frame is MARK, ADDR_W data bits MSB first, MARK. Every token is
//   held on the rails until the receiver raises ACK_IN, then the rails go
//   to spacer until ACK_IN falls again. A wait counter guards each phase;
//   if the receiver stalls for TIMEOUT cycles the frame is abandoned.
//
//   Parameters:
//     ADDR_W  - address bits per frame (1..32)
//     TIMEOUT - max cycles spent waiting for any single ack edge (1..65535)
//
//   Ports:
//     clk        - single clock, rising edge
//     reset      - synchronous, active-high
//     addr_in    - address to send, captured when the request is accepted
//     addr_valid - local source has an address to send
//     addr_ready - transmitter can accept an address this cycle
//     ZERO_OUT   - zero rail to the link (registered)
//     ONE_OUT    - one rail to the link (registered)
//     ACK_IN     - receiver acknowledge, asynchronous to clk
//     busy       - a frame (or a drain after timeout) is in progress
//     frame_done - one-cycle pulse when a frame completes cleanly
//     err        - one-cycle pulse when a handshake times out
// ---------------------------------------------------------------------------
module aer_transmitter
  import aer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              addr_valid,
  output logic              addr_ready,
  output logic              ZERO_OUT,
  output logic              ONE_OUT,
  input  logic              ACK_IN,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  // Token index runs 0 (opening MARK) .. ADDR_W+1 (closing MARK).
  localparam int                IDX_W      = $clog2(ADDR_W + 2);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(ADDR_W + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  aer_state_t        state;
  logic [ADDR_W-1:0] shreg;
  logic [ADDR_W-1:0] shreg_adv;
  logic [IDX_W-1:0]  tok_idx;
  logic [IDX_W-1:0]  idx_adv;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        rails;
  logic [1:0]        next_tok;
  logic              ack_s;
  logic              wait_expired;

  // Only the synchronized acknowledge is ever used by the control logic.
  aer_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (ACK_IN),
    .sync_out (ack_s)
  );

  // Look-ahead for the REL -> REQ step: what the shift register, token
  // index and rail code will be once the current token has been retired.
  // The opening MARK carries no data, so leaving it must not shift the
  // register; after that, each retired data bit shifts the next bit into
  // the MSB, which is always the bit presented on the rails.
  always_comb begin
    shreg_adv = shreg;
    if (tok_idx != '0) begin
      shreg_adv = shreg << 1;
    end
    idx_adv = tok_idx + 1'b1;
    if (idx_adv == LAST_IDX) begin
      next_tok = MARK;
    end else begin
      next_tok = data_token(shreg_adv[ADDR_W-1]);
    end
  end

  // The wait counter is compared one short of TIMEOUT because the edge on
  // which the comparison succeeds is itself the TIMEOUT-th waiting cycle.
  assign wait_expired = (wait_cnt == WAIT_LIMIT);

  // A new address is only taken when idle and the receiver has fully
  // released the previous handshake; a stuck-high ack holds us off.
  assign addr_ready = (state == IDLE) && !ack_s && !reset;
  assign busy       = (state != IDLE);

  assign ONE_OUT  = rails[1];
  assign ZERO_OUT = rails[0];

  // Main controller. Rails, pulses and all datapath state are registered
  // here so the link only ever sees clean flop outputs. While a token is on
  // the rails (REQ) they are left untouched until the receiver acks or the
  // wait expires, and in both cases they drop straight to spacer. The wait
  // counter restarts on every state change so each ack edge gets its own
  // TIMEOUT budget. DRAIN deliberately has no timeout: we simply wait for
  // the receiver to let go, and the aborted frame is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rails      <= SPACER;
      shreg      <= '0;
      tok_idx    <= '0;
      wait_cnt   <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;

      case (state)
        IDLE: begin
          if (addr_valid && addr_ready) begin
            shreg    <= addr_in;
            tok_idx  <= '0;
            wait_cnt <= '0;
            rails    <= MARK;
            state    <= REQ;
          end
        end

        REQ: begin
          if (ack_s) begin
            rails    <= SPACER;
            wait_cnt <= '0;
            state    <= REL;
          end else if (wait_expired) begin
            rails    <= SPACER;
            wait_cnt <= '0;
            err      <= 1'b1;
            state    <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        REL: begin
          if (!ack_s) begin
            wait_cnt <= '0;
            if (tok_idx == LAST_IDX) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              tok_idx <= idx_adv;
              shreg   <= shreg_adv;
              rails   <= next_tok;
              state   <= REQ;
            end
          end else if (wait_expired) begin
            rails    <= SPACER;
            wait_cnt <= '0;
            err      <= 1'b1;
            state    <= DRAIN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DRAIN: begin
          rails <= SPACER;
          if (!ack_s) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end
        end

        default: begin
          rails <= SPACER;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aer_transmitter.sv
// ---------------------------------------------------------------------------
// tb_aer_transmitter
//   Self-checking bench for aer_transmitter (ADDR_W=8, TIMEOUT=15).
//   A receiver model answers the four-phase handshake; a monitor turns the
//   rails and pulses into events and compares them against a queue of
//   expected events built from the address at each accepted request.
// ---------------------------------------------------------------------------
module tb_aer_transmitter;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  localparam int EV_NONE = 0;
  localparam int EV_D0   = 1;
  localparam int EV_D1   = 2;
  localparam int EV_MARK = 3;
  localparam int EV_DONE = 4;
  localparam int EV_ERR  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] addr_in;
  logic              addr_valid;
  logic              addr_ready;
  logic              ZERO_OUT;
  logic              ONE_OUT;
  logic              ACK_IN = 1'b0;
  logic              busy;
  logic              frame_done;
  logic              err;
  logic [1:0]        rails;

  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_q[$];
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   handshakes = 0;
  int   cyc = 0;
  int   last_tok_cyc = 0;
  int   err_cyc = 0;
  int   accept_done_snapshot = 0;
  logic [1:0] prev_rails = 2'b00;

  bit   rx_force = 1'b0;
  bit   rx_force_val = 1'b0;
  bit   rx_rand = 1'b0;
  int   rx_budget = -1;
  int   rx_dly = 3;
  int   rx_cnt = 0;

  assign rails = {ONE_OUT, ZERO_OUT};

  always #5 clk = ~clk;

  aer_transmitter #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr_in    (addr_in),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .ZERO_OUT   (ZERO_OUT),
    .ONE_OUT    (ONE_OUT),
    .ACK_IN     (ACK_IN),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  // One comparison: count it, and report it if the values differ.
  task automatic check_output(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pop the next expected event and compare it with what the DUT produced.
  task automatic sb_check(input string name, input int ev);
    int e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: got event %0d, expected no event", name, ev);
    end else begin
      e = exp_q.pop_front();
      check_output(name, ev, e);
    end
  endtask

  // Reference frame: MARK, address bits MSB first, MARK. Only the first
  // ntok tokens are expected (for aborted frames), followed by tail.
  function automatic void push_expected(input logic [ADDR_W-1:0] a, input int ntok, input int tail);
    int toks[$];
    toks.push_back(EV_MARK);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      toks.push_back(((int'(a) >> i) % 2 == 1) ? EV_D1 : EV_D0);
    end
    toks.push_back(EV_MARK);
    for (int i = 0; i < ntok && i < toks.size(); i++) begin
      exp_q.push_back(toks[i]);
    end
    if (tail != EV_NONE) begin
      exp_q.push_back(tail);
    end
  endfunction

  // Receiver: raises ack rx_dly cycles after a token appears and drops it
  // rx_dly cycles after spacer. rx_budget limits how many tokens get acked
  // (-1 = unlimited); rx_force pins ack to rx_force_val.
  always @(negedge clk) begin
    if (rx_force) begin
      ACK_IN = rx_force_val;
      rx_cnt = 0;
    end else if (!ACK_IN && rails != 2'b00 && rx_budget != 0) begin
      if (rx_cnt >= rx_dly) begin
        ACK_IN = 1'b1;
        rx_cnt = 0;
        handshakes++;
        if (rx_budget > 0) rx_budget--;
        rx_dly = rx_rand ? int'($urandom_range(0, 4)) : 3;
      end else begin
        rx_cnt++;
      end
    end else if (ACK_IN && rails == 2'b00) begin
      if (rx_cnt >= rx_dly) begin
        ACK_IN = 1'b0;
        rx_cnt = 0;
        rx_dly = rx_rand ? int'($urandom_range(0, 4)) : 3;
      end else begin
        rx_cnt++;
      end
    end else begin
      rx_cnt = 0;
    end
  end

  // Monitor: every new token on the rails, every frame_done and every err
  // is checked against the expected-event queue. Rails must always pass
  // through spacer between tokens.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (rails != prev_rails) begin
        check_output("rails_via_spacer", (prev_rails != 2'b00 && rails != 2'b00) ? 1 : 0, 0);
        if (rails != 2'b00) begin
          last_tok_cyc = cyc;
          sb_check("token", int'(rails));
        end
      end
      if (frame_done || err) begin
        check_output("done_err_exclusive", (frame_done && err) ? 1 : 0, 0);
      end
      if (frame_done) begin
        done_cnt++;
        sb_check("frame_done", EV_DONE);
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        sb_check("err", EV_ERR);
      end
    end
    prev_rails = rails;
  end

  // Present an address and wait (bounded) for it to be accepted; on accept
  // the expected events are queued. Optional junk addresses are driven
  // while the frame is busy, which the DUT must ignore.
  task automatic apply_stimulus(input logic [ADDR_W-1:0] a, input int ntok, input int tail,
                                input bit keep_valid, input bit junk);
    bit accepted;
    accepted = 1'b0;
    @(negedge clk);
    addr_in    = a;
    addr_valid = 1'b1;
    for (int i = 0; i < 3000 && !accepted; i++) begin
      if (addr_ready) begin
        @(posedge clk);
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check_output("accept_within_bound", accepted, 1);
    if (accepted) begin
      accept_done_snapshot = done_cnt;
      push_expected(a, ntok, tail);
      #1;
      if (junk) begin
        for (int j = 0; j < 3; j++) begin
          addr_in = ADDR_W'($urandom);
          @(negedge clk);
        end
      end
      if (!keep_valid) addr_valid = 1'b0;
    end else begin
      addr_valid = 1'b0;
    end
  endtask

  // Wait (bounded) until every expected event has been seen and the link
  // is idle again.
  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !ACK_IN) ok = 1'b1;
    end
    check_output(name, ok, 1);
  endtask

  initial begin
    int hs0;
    int d0;
    int e0;
    int k;
    bit ok;
    bit accepted;
    logic [ADDR_W-1:0] ra;

    reset      = 1'b1;
    addr_valid = 1'b0;
    addr_in    = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_output("reset_rails", rails, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_frame_done", frame_done, 0);
    check_output("reset_err", err, 0);
    check_output("reset_addr_ready", addr_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check_output("idle_addr_ready", addr_ready, 1);

    // Clean frame 0xA5 with a responsive receiver
    hs0 = handshakes;
    d0  = done_cnt;
    apply_stimulus(8'hA5, 10, EV_DONE, 1'b0, 1'b0);
    wait_idle("a5_complete");
    check_output("a5_handshakes", handshakes - hs0, 10);
    check_output("a5_done_pulses", done_cnt - d0, 1);

    // Receiver goes silent after the opening MARK
    rx_budget = 1;
    e0 = err_cnt;
    d0 = done_cnt;
    apply_stimulus(8'h5A, 2, EV_ERR, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (err_cnt != e0) ok = 1'b1;
    end
    check_output("timeout_err_seen", ok, 1);
    check_output("timeout_latency", err_cyc - last_tok_cyc, TIMEOUT);
    check_output("timeout_rails_spacer", rails, 0);
    repeat (2) @(negedge clk);
    check_output("timeout_back_to_idle", busy, 0);
    check_output("timeout_addr_ready", addr_ready, 1);
    check_output("timeout_single_err", err_cnt - e0, 1);
    check_output("timeout_no_done", done_cnt - d0, 0);
    rx_budget = -1;

    // Ack stuck high while idle holds off a pending request
    rx_force_val = 1'b1;
    rx_force     = 1'b1;
    repeat (4) @(negedge clk);
    addr_in    = 8'h3C;
    addr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("ack_high_addr_ready", addr_ready, 0);
      check_output("ack_high_rails", rails, 0);
    end
    rx_force_val = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!ACK_IN) ok = 1'b1;
    end
    check_output("ack_release", ok, 1);
    rx_force = 1'b0;
    k = 0;
    accepted = 1'b0;
    while (!accepted && k < 10) begin
      if (addr_ready) begin
        @(posedge clk);
        k++;
        accepted = 1'b1;
      end else begin
        @(posedge clk);
        k++;
        @(negedge clk);
      end
    end
    check_output("ack_fall_accept_latency_ok", (accepted && k <= 3) ? 1 : 0, 1);
    if (accepted) push_expected(8'h3C, 10, EV_DONE);
    #1;
    addr_valid = 1'b0;
    wait_idle("ack_held_frame_complete");

    // Reset during a frame of 0xFF, then a frame of 0x00
    apply_stimulus(8'hFF, 6, EV_NONE, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    check_output("reset_mid_reached_bit", ok, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    reset = 1'b1;
    @(negedge clk);
    check_output("reset_mid_rails", rails, 0);
    check_output("reset_mid_busy", busy, 0);
    check_output("reset_mid_frame_done", frame_done, 0);
    check_output("reset_mid_err", err, 0);
    @(negedge clk);
    check_output("reset_mid_frame_done_2", frame_done, 0);
    check_output("reset_mid_err_2", err, 0);
    reset = 1'b0;
    apply_stimulus(8'h00, 10, EV_DONE, 1'b0, 1'b0);
    wait_idle("after_reset_frame_complete");
    check_output("after_reset_done_count", done_cnt - d0, 1);
    check_output("after_reset_err_count", err_cnt - e0, 0);

    // Back-to-back requests 0x01 then 0x80
    hs0 = handshakes;
    d0  = done_cnt;
    apply_stimulus(8'h01, 10, EV_DONE, 1'b1, 1'b0);
    apply_stimulus(8'h80, 10, EV_DONE, 1'b0, 1'b0);
    check_output("b2b_second_after_done", accept_done_snapshot - d0, 1);
    wait_idle("b2b_complete");
    check_output("b2b_handshakes", handshakes - hs0, 20);
    check_output("b2b_done_pulses", done_cnt - d0, 2);

    // Randomized addresses, receiver delays and ignored requests while busy
    rx_rand = 1'b1;
    hs0 = handshakes;
    d0  = done_cnt;
    for (int f = 0; f < 12; f++) begin
      ra = ADDR_W'($urandom);
      apply_stimulus(ra, 10, EV_DONE, 1'b0, 1'b1);
      wait_idle("rand_frame_complete");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check_output("rand_handshakes", handshakes - hs0, 120);
    check_output("rand_done_pulses", done_cnt - d0, 12);

    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Last-resort guard so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
